// File: rtl/gen_step_ctrl.sv
// Generation-step controller: synchronises the flush clock, turns each rising edge into a
// step request for the life engine and counts generations. Option: STEP_OVERRUN_CNT_EN.
module gen_step_ctrl #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
`ifdef STEP_OVERRUN_CNT_EN
  ,
  parameter int OVR_W       = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_clk,
  input  logic [3:0]       usr_op,
  input  logic             step_done,
  output logic             step_req,
  output logic             clr_pulse,
  output logic             running,
  output logic [CNT_W-1:0] gen_count
`ifdef STEP_OVERRUN_CNT_EN
  ,
  output logic [OVR_W-1:0] ovr_count
`endif
);

  typedef enum logic [1:0] {ST_PAUSE, ST_RUN, ST_BUSY, ST_CLR} state_t;

  state_t               state_q, state_d;
  logic                 running_q, running_d;
  logic                 tick_pend_q, tick_pend_d;
  logic                 clr_pend_q, clr_pend_d;
  logic [CNT_W-1:0]     gen_q, gen_d;
  logic [3:0]           usr_q;
  logic [3:0]           usr_rise;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 sync_dly_q;
  logic                 tick;
  logic                 drop_tick;
  logic                 enter_clr;

  // Tick is the rising edge seen at the end of the synchroniser chain.
  assign tick     = sync_q[SYNC_STAGES-1] & ~sync_dly_q;
  assign usr_rise = usr_op & ~usr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q     <= '0;
      sync_dly_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], flush_clk};
      sync_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    state_d     = state_q;
    running_d   = running_q;
    tick_pend_d = tick_pend_q;
    clr_pend_d  = clr_pend_q;
    gen_d       = gen_q;
    drop_tick   = 1'b0;
    enter_clr   = 1'b0;
    case (state_q)
      ST_PAUSE: begin
        if (usr_rise[3]) begin
          enter_clr = 1'b1;
        end else if (!usr_rise[1]) begin
          if (usr_rise[2]) begin
            state_d = ST_BUSY;
          end else if (usr_rise[0]) begin
            state_d   = ST_RUN;
            running_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (usr_rise[3]) begin
          enter_clr = 1'b1;
        end else if (usr_rise[1]) begin
          state_d   = ST_PAUSE;
          running_d = 1'b0;
        end else if (tick || tick_pend_q) begin
          state_d     = ST_BUSY;
          tick_pend_d = 1'b0;
        end
      end
      ST_BUSY: begin
        // The in-flight step always completes; a clear is only remembered.
        if (usr_rise[3]) begin
          clr_pend_d = 1'b1;
        end else if (usr_rise[1]) begin
          running_d = 1'b0;
        end else if (usr_rise[0]) begin
          running_d = 1'b1;
        end
        if (tick && running_q) begin
          if (tick_pend_q) drop_tick = 1'b1;
          else             tick_pend_d = 1'b1;
        end
        if (step_done) begin
          gen_d = gen_q + CNT_W'(1);
          if (clr_pend_q || usr_rise[3]) enter_clr = 1'b1;
          else if (running_d)            state_d = ST_RUN;
          else                           state_d = ST_PAUSE;
        end
      end
      default: state_d = ST_PAUSE;
    endcase
    if (enter_clr) begin
      state_d     = ST_CLR;
      gen_d       = '0;
      tick_pend_d = 1'b0;
      clr_pend_d  = 1'b0;
      running_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_PAUSE;
      running_q   <= 1'b0;
      tick_pend_q <= 1'b0;
      clr_pend_q  <= 1'b0;
      gen_q       <= '0;
      usr_q       <= '0;
    end else begin
      state_q     <= state_d;
      running_q   <= running_d;
      tick_pend_q <= tick_pend_d;
      clr_pend_q  <= clr_pend_d;
      gen_q       <= gen_d;
      usr_q       <= usr_op;
    end
  end

`ifdef STEP_OVERRUN_CNT_EN
  logic [OVR_W-1:0] ovr_q;

  always_ff @(posedge clk) begin
    if (!rst || enter_clr) begin
      ovr_q <= '0;
    end else if (drop_tick && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_q <= ovr_q + OVR_W'(1);
    end
  end

  assign ovr_count = ovr_q;
`else
  logic unused_drop;
  assign unused_drop = drop_tick;
`endif

  assign step_req  = (state_q == ST_BUSY);
  assign clr_pulse = (state_q == ST_CLR);
  assign running   = running_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_gen_step_ctrl.sv
// Self-checking bench for gen_step_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model of the controller.
module tb_gen_step_ctrl;
  localparam int CNT_W   = 4;
  localparam int M_PAUSE = 0;
  localparam int M_RUN   = 1;
  localparam int M_BUSY  = 2;
  localparam int M_CLR   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_clk;
  logic [3:0]       usr_op;
  logic             step_done;
  logic             step_req;
  logic             clr_pulse;
  logic             running;
  logic [CNT_W-1:0] gen_count;
`ifdef STEP_OVERRUN_CNT_EN
  logic [7:0]       ovr_count;
`endif

  always #5 clk = ~clk;

  gen_step_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_clk (flush_clk),
    .usr_op    (usr_op),
    .step_done (step_done),
    .step_req  (step_req),
    .clr_pulse (clr_pulse),
    .running   (running),
    .gen_count (gen_count)
`ifdef STEP_OVERRUN_CNT_EN
    ,
    .ovr_count (ovr_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int       m_mode = M_PAUSE;
  bit       m_run = 0, m_pend = 0, m_cpend = 0;
  int       m_cnt = 0, m_ovr = 0;
  bit       h1 = 0, h2 = 0, h3 = 0;
  bit [3:0] m_usr = 0;

  int dut_req_rises = 0, m_req_rises = 0, dut_clr_pulses = 0;
  bit prev_req = 0, prev_mreq = 0;
  bit eng_auto = 0;
  int eng_delay = 5, eng_wait = 0;

  task automatic model_clock();
    bit       tick, was_run, clr_now;
    bit [3:0] ed;
    if (!rst) begin
      m_mode = M_PAUSE; m_run = 0; m_pend = 0; m_cpend = 0; m_cnt = 0; m_ovr = 0;
      h1 = 0; h2 = 0; h3 = 0; m_usr = 0;
      return;
    end
    tick = h2 && !h3;
    h3 = h2; h2 = h1; h1 = flush_clk;
    ed = usr_op & ~m_usr;
    m_usr = usr_op;
    clr_now = 0;
    was_run = m_run;
    case (m_mode)
      M_PAUSE: begin
        if (ed[3]) clr_now = 1;
        else if (!ed[1]) begin
          if (ed[2]) m_mode = M_BUSY;
          else if (ed[0]) begin m_run = 1; m_mode = M_RUN; end
        end
      end
      M_RUN: begin
        if (ed[3]) clr_now = 1;
        else if (ed[1]) begin m_run = 0; m_mode = M_PAUSE; end
        else if (tick || m_pend) begin m_mode = M_BUSY; m_pend = 0; end
      end
      M_BUSY: begin
        if (ed[3]) m_cpend = 1;
        else if (ed[1]) m_run = 0;
        else if (ed[0]) m_run = 1;
        if (tick && was_run) begin
          if (m_pend) begin if (m_ovr < 255) m_ovr++; end
          else m_pend = 1;
        end
        if (step_done) begin
          m_cnt = (m_cnt + 1) % (1 << CNT_W);
          if (m_cpend) clr_now = 1;
          else m_mode = m_run ? M_RUN : M_PAUSE;
        end
      end
      default: m_mode = M_PAUSE;
    endcase
    if (clr_now) begin
      m_mode = M_CLR; m_cnt = 0; m_pend = 0; m_cpend = 0; m_run = 0; m_ovr = 0;
    end
  endtask

  // One clk period: model follows the edge, bench then acts as the engine at negedge.
  task automatic cycle();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    if (step_req === 1'b1 && !prev_req) dut_req_rises++;
    prev_req = (step_req === 1'b1);
    if (m_mode == M_BUSY && !prev_mreq) m_req_rises++;
    prev_mreq = (m_mode == M_BUSY);
    if (clr_pulse === 1'b1) dut_clr_pulses++;
    step_done = 1'b0;
    if (eng_auto && m_mode == M_BUSY) begin
      eng_wait++;
      if (eng_wait >= eng_delay) begin step_done = 1'b1; eng_wait = 0; end
    end else begin
      eng_wait = 0;
    end
  endtask

  task automatic flush_periods(input int n, input int half);
    for (int p = 0; p < n; p++) begin
      flush_clk = 1'b1;
      repeat (half) cycle();
      flush_clk = 1'b0;
      repeat (half) cycle();
    end
  endtask

  task automatic test_reset();
    int r0;
    rst = 1'b0; flush_clk = 1'b0; usr_op = 4'b0; step_done = 1'b0; eng_auto = 0;
    @(negedge clk);
    cycle();
    flush_clk = 1'b1;
    cycle();
    checks += 4;
    if (step_req !== 1'b0) begin errors++; $display("FAIL reset_step_req: got %b expected 0", step_req); end
    if (clr_pulse !== 1'b0) begin errors++; $display("FAIL reset_clr_pulse: got %b expected 0", clr_pulse); end
    if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b expected 0", running); end
    if (gen_count !== 4'd0) begin errors++; $display("FAIL reset_gen_count: got %0d expected 0", gen_count); end
    rst = 1'b1;
    flush_clk = 1'b0;
    r0 = dut_req_rises;
    flush_periods(3, 4);
    checks += 2;
    if (dut_req_rises - r0 != 0) begin errors++; $display("FAIL reset_pause_ticks: got %0d step_req rises expected 0", dut_req_rises - r0); end
    if (running !== 1'b0) begin errors++; $display("FAIL reset_pause_running: got %b expected 0", running); end
    $display("test_reset: step_req=%b running=%b gen_count=%0d", step_req, running, gen_count);
  endtask

  task automatic test_run();
    int r0;
    r0 = dut_req_rises;
    usr_op = 4'b0001; cycle();
    usr_op = 4'b0000; cycle();
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL run_mode: got running=%b expected 1", running); end
    eng_auto = 1; eng_delay = 5;
    for (int p = 0; p < 3; p++) begin
      flush_clk = 1'b1;
      cycle();
      checks++;
      if (step_req !== 1'b0) begin errors++; $display("FAIL run_latency_e1: got %b expected 0", step_req); end
      cycle();
      checks++;
      if (step_req !== 1'b0) begin errors++; $display("FAIL run_latency_e2: got %b expected 0", step_req); end
      cycle();
      checks++;
      if (step_req !== 1'b1) begin errors++; $display("FAIL run_latency_e3: got %b expected 1", step_req); end
      repeat (7) cycle();
      flush_clk = 1'b0;
      repeat (10) cycle();
    end
    checks += 3;
    if (dut_req_rises - r0 != 3) begin errors++; $display("FAIL run_req_count: got %0d expected 3", dut_req_rises - r0); end
    if (gen_count !== 4'd3) begin errors++; $display("FAIL run_gen_count: got %0d expected 3", gen_count); end
    if (running !== 1'b1) begin errors++; $display("FAIL run_running: got %b expected 1", running); end
    $display("test_run: requests=%0d gen_count=%0d running=%b", dut_req_rises - r0, gen_count, running);
  endtask

  task automatic test_single_step();
    int r0;
    usr_op = 4'b0010; cycle();
    usr_op = 4'b0000; cycle();
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL step_pause: got running=%b expected 0", running); end
    r0 = dut_req_rises;
    eng_auto = 1; eng_delay = 2;
    usr_op = 4'b0100;
    repeat (10) cycle();
    usr_op = 4'b0000;
    repeat (5) cycle();
    checks += 2;
    if (dut_req_rises - r0 != 1) begin errors++; $display("FAIL step_req_count: got %0d expected 1", dut_req_rises - r0); end
    if (gen_count !== 4'd4) begin errors++; $display("FAIL step_gen_count: got %0d expected 4", gen_count); end
    $display("test_single_step: requests=%0d gen_count=%0d", dut_req_rises - r0, gen_count);
  endtask

  task automatic test_overrun();
    int r0;
    usr_op = 4'b0001; cycle();
    usr_op = 4'b0000; cycle();
    r0 = dut_req_rises;
    eng_auto = 0;
    flush_periods(3, 4);
    checks += 2;
    if (step_req !== 1'b1) begin errors++; $display("FAIL ovr_held_req: got %b expected 1", step_req); end
    if (gen_count !== 4'd4) begin errors++; $display("FAIL ovr_held_count: got %0d expected 4", gen_count); end
    eng_auto = 1; eng_delay = 3;
    repeat (20) cycle();
    checks += 3;
    if (gen_count !== 4'd6) begin errors++; $display("FAIL ovr_gen_count: got %0d expected 6", gen_count); end
    if (dut_req_rises - r0 != 2) begin errors++; $display("FAIL ovr_req_count: got %0d expected 2", dut_req_rises - r0); end
    if (step_req !== 1'b0) begin errors++; $display("FAIL ovr_idle_req: got %b expected 0", step_req); end
`ifdef STEP_OVERRUN_CNT_EN
    checks++;
    if (ovr_count !== 8'd1) begin errors++; $display("FAIL ovr_count: got %0d expected 1", ovr_count); end
`endif
    $display("test_overrun: requests=%0d gen_count=%0d", dut_req_rises - r0, gen_count);
  endtask

  task automatic test_clear_busy();
    int r0, c0;
    eng_auto = 0;
    flush_periods(1, 4);
    checks++;
    if (step_req !== 1'b1) begin errors++; $display("FAIL clr_busy_req: got %b expected 1", step_req); end
    c0 = dut_clr_pulses;
    usr_op = 4'b1000; cycle();
    usr_op = 4'b0000; cycle();
    checks += 3;
    if (step_req !== 1'b1) begin errors++; $display("FAIL clr_not_aborted: got %b expected 1", step_req); end
    if (clr_pulse !== 1'b0) begin errors++; $display("FAIL clr_deferred: got %b expected 0", clr_pulse); end
    if (gen_count !== 4'd6) begin errors++; $display("FAIL clr_pre_count: got %0d expected 6", gen_count); end
    step_done = 1'b1;
    cycle();
    checks += 4;
    if (clr_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse_high: got %b expected 1", clr_pulse); end
    if (step_req !== 1'b0) begin errors++; $display("FAIL clr_req_low: got %b expected 0", step_req); end
    if (gen_count !== 4'd0) begin errors++; $display("FAIL clr_gen_count: got %0d expected 0", gen_count); end
    if (running !== 1'b0) begin errors++; $display("FAIL clr_running: got %b expected 0", running); end
    cycle();
    r0 = dut_req_rises;
    flush_periods(2, 4);
    checks += 3;
    if (dut_clr_pulses - c0 != 1) begin errors++; $display("FAIL clr_pulse_len: got %0d cycles expected 1", dut_clr_pulses - c0); end
    if (dut_req_rises - r0 != 0) begin errors++; $display("FAIL clr_then_pause: got %0d requests expected 0", dut_req_rises - r0); end
    if (running !== 1'b0) begin errors++; $display("FAIL clr_pause_running: got %b expected 0", running); end
    $display("test_clear_busy: clr_cycles=%0d gen_count=%0d", dut_clr_pulses - c0, gen_count);
  endtask

  task automatic test_wrap();
    eng_auto = 1; eng_delay = 1;
    for (int i = 0; i < 16; i++) begin
      usr_op = 4'b0100; cycle();
      usr_op = 4'b0000; repeat (4) cycle();
      if (i == 14) begin
        checks++;
        if (gen_count !== 4'd15) begin errors++; $display("FAIL wrap_max: got %0d expected 15", gen_count); end
      end
    end
    checks++;
    if (gen_count !== 4'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", gen_count); end
    usr_op = 4'b0100; cycle();
    usr_op = 4'b0000; repeat (4) cycle();
    usr_op = 4'b1111; cycle();
    checks += 3;
    if (clr_pulse !== 1'b1) begin errors++; $display("FAIL prio_clear: got %b expected 1", clr_pulse); end
    if (gen_count !== 4'd0) begin errors++; $display("FAIL prio_count: got %0d expected 0", gen_count); end
    if (step_req !== 1'b0) begin errors++; $display("FAIL prio_no_step: got %b expected 0", step_req); end
    usr_op = 4'b0000; cycle();
    checks += 2;
    if (running !== 1'b0) begin errors++; $display("FAIL prio_no_run: got %b expected 0", running); end
    if (clr_pulse !== 1'b0) begin errors++; $display("FAIL prio_pulse_end: got %b expected 0", clr_pulse); end
    $display("test_wrap: gen_count=%0d running=%b", gen_count, running);
  endtask

  task automatic test_random();
    int half, left, bad;
    eng_auto = 1; eng_delay = 4;
    half = 6; left = 6;
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 400) != 0);
      usr_op = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
      if (--left <= 0) begin
        flush_clk = ~flush_clk;
        half = $urandom_range(3, 15);
        left = half;
      end
      if ($urandom_range(0, 20) == 0) eng_delay = $urandom_range(1, 12);
      cycle();
      if ($urandom_range(0, 30) == 0) step_done = 1'b1;
      checks += 4;
      if (step_req !== (m_mode == M_BUSY)) begin errors++; bad++; $display("FAIL rnd_step_req: cycle %0d got %b expected %b", n, step_req, m_mode == M_BUSY); end
      if (clr_pulse !== (m_mode == M_CLR)) begin errors++; bad++; $display("FAIL rnd_clr_pulse: cycle %0d got %b expected %b", n, clr_pulse, m_mode == M_CLR); end
      if (running !== m_run) begin errors++; bad++; $display("FAIL rnd_running: cycle %0d got %b expected %b", n, running, m_run); end
      if (gen_count !== 4'(m_cnt)) begin errors++; bad++; $display("FAIL rnd_gen_count: cycle %0d got %0d expected %0d", n, gen_count, m_cnt); end
`ifdef STEP_OVERRUN_CNT_EN
      checks++;
      if (ovr_count !== 8'(m_ovr)) begin errors++; bad++; $display("FAIL rnd_ovr_count: cycle %0d got %0d expected %0d", n, ovr_count, m_ovr); end
`endif
    end
    rst = 1'b1; usr_op = 4'b0000;
    $display("test_random: 3000 cycles, %0d mismatching cycles, model requests=%0d", bad, m_req_rises);
  endtask

  initial begin
    test_reset();
    test_run();
    test_single_step();
    test_overrun();
    test_clear_busy();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
